// File: rtl/render_seq_if.sv
// Command/status bundle between the command decoder, the render sequencer and
// the line-draw / clear / pixel-bus units.
interface render_seq_if #(
  parameter int OP_W  = 3,
  parameter int SEG_W = 3
);
  logic            render_enable;
  logic [OP_W-1:0] op;
  logic            done;
  logic            clear_done;
  logic            out_ready;
  logic            abort;

  logic             draw_enable;
  logic             set_new;
  logic             line_draw_out;
  logic             enable;
  logic             clear_enable;
  logic [SEG_W-1:0] seg_idx;
  logic             busy;
  logic             render_done;
  logic             op_err;

  modport master (
    output render_enable, op, done, clear_done, out_ready, abort,
    input  draw_enable, set_new, line_draw_out, enable, clear_enable,
           seg_idx, busy, render_done, op_err
  );

  modport slave (
    input  render_enable, op, done, clear_done, out_ready, abort,
    output draw_enable, set_new, line_draw_out, enable, clear_enable,
           seg_idx, busy, render_done, op_err
  );
endinterface

// File: rtl/render_seq_ctrl.sv
// Render sequencer: steps CLEAR, LINE and multi-segment POLY commands through
// the line drawer / clear unit with send backpressure, post-send wait and abort.
//
// state | meaning
// IDLE  | waiting for render_enable, op captured on start
// LOAD  | line drawer loads endpoints of seg_idx and takes one step
// STEP  | line drawer takes one step on the current segment
// SEND  | pixel write strobe held until out_ready
// WAIT  | WAIT_CYC cycles; last one decides STEP / next segment / FIN
// CSEND | clear pixel write strobe held until out_ready
// CNEXT | advance clear address
// CWAIT | WAIT_CYC cycles; last one checks clear_done
// FIN   | command finished; render_done follows next cycle
module render_seq_ctrl #(
  parameter int OP_W     = 3,
  parameter int WAIT_CYC = 2,
  parameter int POLY_SEG = 4,
  parameter int SEG_W    = 3
) (
  input  logic         clk,
  input  logic         n_rst,
  render_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD, STEP, SEND, WAIT, CSEND, CNEXT, CWAIT, FIN
  } state_t;

  localparam logic [OP_W-1:0]  OP_CLEAR  = OP_W'(0);
  localparam logic [OP_W-1:0]  OP_LINE   = OP_W'(1);
  localparam logic [OP_W-1:0]  OP_POLY   = OP_W'(2);
  localparam logic [3:0]       WAIT_LAST = 4'(WAIT_CYC - 1);
  localparam logic [SEG_W-1:0] POLY_LAST = SEG_W'(POLY_SEG - 1);

  state_t           state, state_nx;
  logic [3:0]       wait_cnt, wait_cnt_nx;
  logic [SEG_W-1:0] seg_q, seg_nx;
  logic [OP_W-1:0]  op_reg, op_reg_nx;
  logic             render_done_q, op_err_q, op_err_nx;
  logic [SEG_W-1:0] last_seg;
  logic             wait_last, abort_act;

  assign last_seg  = (op_reg == OP_POLY) ? POLY_LAST : '0;
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign abort_act = bus.abort && (state != IDLE) && (state != FIN);

  assign bus.seg_idx     = seg_q;
  assign bus.busy        = (state != IDLE);
  assign bus.render_done = render_done_q;
  assign bus.op_err      = op_err_q;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      seg_q         <= '0;
      op_reg        <= '0;
      render_done_q <= 1'b0;
      op_err_q      <= 1'b0;
    end else begin
      state         <= state_nx;
      wait_cnt      <= wait_cnt_nx;
      seg_q         <= seg_nx;
      op_reg        <= op_reg_nx;
      render_done_q <= (state == FIN);
      op_err_q      <= op_err_nx;
    end
  end

  always_comb begin
    state_nx          = state;
    wait_cnt_nx       = wait_cnt;
    seg_nx            = seg_q;
    op_reg_nx         = op_reg;
    op_err_nx         = 1'b0;
    bus.draw_enable   = 1'b0;
    bus.set_new       = 1'b0;
    bus.line_draw_out = 1'b0;
    bus.enable        = 1'b0;
    bus.clear_enable  = 1'b0;

    case (state)
      IDLE: begin
        if (bus.render_enable) begin
          op_reg_nx = bus.op;
          if (bus.op == OP_LINE || bus.op == OP_POLY) begin
            seg_nx   = '0;
            state_nx = LOAD;
          end else if (bus.op == OP_CLEAR) begin
            state_nx = CSEND;
          end else begin
            op_err_nx = 1'b1;
            state_nx  = FIN;
          end
        end
      end
      LOAD: begin
        bus.draw_enable   = 1'b1;
        bus.set_new       = 1'b1;
        bus.line_draw_out = 1'b1;
        state_nx          = SEND;
      end
      STEP: begin
        bus.draw_enable   = 1'b1;
        bus.line_draw_out = 1'b1;
        state_nx          = SEND;
      end
      SEND: begin
        bus.enable        = 1'b1;
        bus.line_draw_out = 1'b1;
        if (bus.out_ready) begin
          wait_cnt_nx = '0;
          state_nx    = WAIT;
        end
      end
      WAIT: begin
        bus.line_draw_out = 1'b1;
        if (wait_last) begin
          if (!bus.done) begin
            state_nx = STEP;
          end else if (seg_q == last_seg) begin
            state_nx = FIN;
          end else begin
            seg_nx   = seg_q + SEG_W'(1);
            state_nx = LOAD;
          end
        end else begin
          wait_cnt_nx = wait_cnt + 4'd1;
        end
      end
      CSEND: begin
        bus.enable = 1'b1;
        if (bus.out_ready) state_nx = CNEXT;
      end
      CNEXT: begin
        bus.clear_enable = 1'b1;
        wait_cnt_nx      = '0;
        state_nx         = CWAIT;
      end
      CWAIT: begin
        if (wait_last) state_nx = bus.clear_done ? FIN : CSEND;
        else           wait_cnt_nx = wait_cnt + 4'd1;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // Abort wins over out_ready/done and silences this cycle's strobes.
    if (abort_act) begin
      bus.draw_enable  = 1'b0;
      bus.set_new      = 1'b0;
      bus.enable       = 1'b0;
      bus.clear_enable = 1'b0;
      state_nx         = FIN;
    end
  end

endmodule

// File: tb/tb_render_seq_ctrl.sv
// Scoreboard bench for render_seq_ctrl: per-command strobe totals and per-load
// segment indices are queued at issue time and compared as the DUT produces them.
module tb_render_seq_ctrl;

  localparam int OP_W     = 3;
  localparam int WAIT_CYC = 2;
  localparam int POLY_SEG = 4;
  localparam int SEG_W    = 3;

  typedef struct {
    int sn;
    int en;
    int clr;
    int ldo;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  render_seq_if #(.OP_W(OP_W), .SEG_W(SEG_W)) bus ();

  render_seq_ctrl #(
    .OP_W(OP_W), .WAIT_CYC(WAIT_CYC), .POLY_SEG(POLY_SEG), .SEG_W(SEG_W)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   seg_q[$];

  int cnt_sn, cnt_en, cnt_clr, cnt_ldo, cnt_err, pop;
  int prev_rd;
  int nlow = 0;
  int nclr = 1;
  int sends, clrs;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_exp(input int sn, input int en, input int clr, input int ldo, input int err);
    exp_t e;
    e.sn = sn; e.en = en; e.clr = clr; e.ldo = ldo; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic start(input int o);
    @(posedge clk); #1;
    bus.op = OP_W'(o);
    bus.render_enable = 1'b1;
    @(posedge clk); #1;
    bus.render_enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
    if (n >= 300) check_val("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_enable_neg();
    int n = 0;
    while (n < 30) begin
      @(negedge clk);
      if (bus.enable) break;
      n++;
    end
    if (n >= 30) check_val("enable_timeout", 1, 0);
  endtask

  // Monitor: accumulate strobes per command, settle against the scoreboard on render_done.
  always @(negedge clk) begin
    if (!n_rst) begin
      cnt_sn = 0; cnt_en = 0; cnt_clr = 0; cnt_ldo = 0; cnt_err = 0; prev_rd = 0;
    end else begin
      pop = int'(bus.draw_enable) + int'(bus.enable) + int'(bus.clear_enable);
      if (pop != 0) check_val("strobe_excl", pop, 1);
      if (bus.set_new) begin
        check_val("setnew_draw", int'(bus.draw_enable), 1);
        cnt_sn++;
        if (seg_q.size() > 0) check_val("seg_idx", int'(bus.seg_idx), seg_q.pop_front());
        else check_val("seg_unexpected", 1, 0);
      end
      if (bus.enable) cnt_en++;
      if (bus.clear_enable) cnt_clr++;
      if (bus.line_draw_out) cnt_ldo = 1;
      if (bus.op_err) cnt_err++;
      if (bus.render_done) begin
        check_val("done_pulse", prev_rd, 0);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("set_new_cnt", cnt_sn, e.sn);
          check_val("enable_cnt", cnt_en, e.en);
          check_val("clear_en_cnt", cnt_clr, e.clr);
          check_val("line_draw_seen", cnt_ldo, e.ldo);
          check_val("op_err_cnt", cnt_err, e.err);
        end else begin
          check_val("done_unexpected", 1, 0);
        end
        cnt_sn = 0; cnt_en = 0; cnt_clr = 0; cnt_ldo = 0; cnt_err = 0;
      end
      prev_rd = int'(bus.render_done);
    end
  end

  // Responder: line drawer reports done after nlow not-done decisions per segment;
  // clear unit reports clear_done on the nclr-th clear send.
  always @(negedge clk) begin
    if (bus.busy !== 1'b1) begin
      sends = 0; clrs = 0;
      bus.done = 1'b0;
      bus.clear_done = 1'b0;
    end else if (bus.enable && bus.out_ready) begin
      if (bus.line_draw_out) begin
        if (sends == nlow) begin bus.done = 1'b1; sends = 0; end
        else begin bus.done = 1'b0; sends++; end
      end else begin
        clrs++;
        bus.clear_done = (clrs == nclr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_rst = 1'b0;
    bus.render_enable = 1'b0;
    bus.op = '0;
    bus.out_ready = 1'b1;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_busy", int'(bus.busy), 0);
    check_val("rst_seg", int'(bus.seg_idx), 0);
    check_val("rst_render_done", int'(bus.render_done), 0);
    check_val("rst_op_err", int'(bus.op_err), 0);
    check_val("rst_enable", int'(bus.enable), 0);
    check_val("rst_ldo", int'(bus.line_draw_out), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Minimum-latency single LINE
    nlow = 0;
    push_exp(1, 1, 0, 1, 0); seg_q.push_back(0);
    start(1);
    @(negedge clk);
    check_val("lat_c1_set_new", int'(bus.set_new), 1);
    check_val("lat_c1_busy", int'(bus.busy), 1);
    @(negedge clk);
    check_val("lat_c2_enable", int'(bus.enable), 1);
    check_val("lat_c2_set_new", int'(bus.set_new), 0);
    @(negedge clk);
    check_val("lat_c3_enable", int'(bus.enable), 0);
    check_val("lat_c3_ldo", int'(bus.line_draw_out), 1);
    @(negedge clk);
    check_val("lat_c4_busy", int'(bus.busy), 1);
    @(negedge clk);
    check_val("lat_c5_busy", int'(bus.busy), 1);
    check_val("lat_c5_ldo", int'(bus.line_draw_out), 0);
    check_val("lat_c5_rd", int'(bus.render_done), 0);
    @(negedge clk);
    check_val("lat_c6_rd", int'(bus.render_done), 1);
    check_val("lat_c6_busy", int'(bus.busy), 0);
    @(negedge clk);
    check_val("lat_c7_rd", int'(bus.render_done), 0);
    repeat (2) @(negedge clk);

    // POLY, two not-done decisions per segment; start request mid-command ignored
    nlow = 2;
    push_exp(4, 12, 0, 1, 0);
    for (int i = 0; i < POLY_SEG; i++) seg_q.push_back(i);
    start(2);
    @(posedge clk); #1;
    bus.render_enable = 1'b1; bus.op = OP_W'(5);
    @(posedge clk); #1;
    bus.render_enable = 1'b0; bus.op = OP_W'(2);
    wait_idle();

    // CLEAR finishing on the third decision
    nclr = 3;
    push_exp(0, 3, 3, 0, 0);
    start(0);
    wait_idle();

    // Backpressure: out_ready low for 5 SEND cycles
    nlow = 0;
    bus.out_ready = 1'b0;
    push_exp(1, 6, 0, 1, 0); seg_q.push_back(0);
    start(1);
    wait_enable_neg();
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle();

    // Abort in SEND masks the strobe
    push_exp(1, 0, 0, 1, 0); seg_q.push_back(0);
    start(1);
    n = 0;
    while (n < 30) begin
      if (bus.enable) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) check_val("abort_send_timeout", 1, 0);
    bus.abort = 1'b1;
    @(negedge clk);
    check_val("abort_mask_en", int'(bus.enable), 0);
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check_val("abort_send_fin_busy", int'(bus.busy), 1);
    check_val("abort_send_fin_ldo", int'(bus.line_draw_out), 0);
    wait_idle();

    // Abort in WAIT of POLY segment 2
    push_exp(3, 3, 0, 1, 0);
    for (int i = 0; i < 3; i++) seg_q.push_back(i);
    start(2);
    n = 0;
    while (n < 100) begin
      if (bus.seg_idx == SEG_W'(2) && bus.line_draw_out && !bus.enable && !bus.draw_enable) break;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_val("abort_wait_timeout", 1, 0);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check_val("abort_wait_fin_busy", int'(bus.busy), 1);
    check_val("abort_wait_fin_ldo", int'(bus.line_draw_out), 0);
    wait_idle();

    // Next LINE starts again from segment 0
    push_exp(1, 1, 0, 1, 0); seg_q.push_back(0);
    start(1);
    wait_idle();

    // Illegal op
    push_exp(0, 0, 0, 0, 1);
    start(5);
    @(negedge clk);
    check_val("illegal_op_err", int'(bus.op_err), 1);
    check_val("illegal_busy", int'(bus.busy), 1);
    wait_idle();

    // Synchronous reset while holding in SEND
    bus.out_ready = 1'b0;
    seg_q.push_back(0);
    start(1);
    wait_enable_neg();
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("srst_busy", int'(bus.busy), 0);
    check_val("srst_enable", int'(bus.enable), 0);
    check_val("srst_ldo", int'(bus.line_draw_out), 0);
    check_val("srst_draw", int'(bus.draw_enable), 0);
    check_val("srst_seg", int'(bus.seg_idx), 0);
    check_val("srst_rd", int'(bus.render_done), 0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    bus.out_ready = 1'b1;

    push_exp(1, 1, 0, 1, 0); seg_q.push_back(0);
    start(1);
    wait_idle();

    repeat (3) @(negedge clk);
    check_val("sb_empty", exp_q.size(), 0);
    check_val("seg_q_empty", seg_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/render_seq_ctrl.md
Name: render_seq_ctrl

Overview:
Parametrised successor to the render control FSM: sequences multi-segment draw commands and screen clears for the line-draw/pixel-write pipeline. Ops: CLEAR, single LINE, and multi-segment RECT/POLY.
Adds over the previous generation: programmable post-send wait depth, downstream ready backpressure on the send strobe, segment indexing for vertex selection, abort, and illegal-op reporting.
Sits between the command decoder (render_enable/op) and the line drawer, clear unit and pixel output bus.

Parameters:
OP_W, 3, width of op code
WAIT_CYC, 2, cycles spent in WAIT/CWAIT after each send; done sampled in last one; legal range 1..15
POLY_SEG, 4, segments for OP_POLY (RECT = 4); legal range 1..2**SEG_W
SEG_W, 3, width of seg_idx

Ports:
clk  in  1  system clock
n_rst  in  1  reset, synchronous, active-low
render_enable  in  1  start request; sampled only in IDLE
op  in  OP_W  command; captured at start: 0=CLEAR, 1=LINE, 2=POLY; others illegal
done  in  1  line drawer finished current segment
clear_done  in  1  clear unit reached last address
out_ready  in  1  downstream accepts enable strobe
abort  in  1  cancel current command
draw_enable  out  1  advance line drawer one step
set_new  out  1  line drawer loads endpoints of seg_idx
line_draw_out  out  1  pixel bus muxed to line drawer
enable  out  1  pixel write strobe
clear_enable  out  1  advance clear address
seg_idx  out  SEG_W  current segment number
busy  out  1  high in every state except IDLE
render_done  out  1  registered one-cycle completion pulse
op_err  out  1  registered one-cycle pulse on illegal op

Behaviour:
- Reset: n_rst==0 at posedge -> state IDLE, seg_idx=0, wait counter=0, op_reg=0, render_done=0, op_err=0. All combinational outputs 0 in IDLE. A reset asserted mid-command takes effect at that edge; there is no flush.
- States: IDLE, LOAD, STEP, SEND, WAIT, CSEND, CNEXT, CWAIT, FIN.
- IDLE, render_enable=1:
  - LINE/POLY: op_reg<=op, seg_idx<=0 -> LOAD.
  - CLEAR: op_reg<=op -> CSEND.
  - Illegal op: op_err pulses next cycle -> FIN.
- LINE/POLY path:
  - LOAD: draw_enable=1, set_new=1, line_draw_out=1 -> SEND.
  - STEP: draw_enable=1, line_draw_out=1 -> SEND.
  - SEND: enable=1, line_draw_out=1. Hold SEND with enable high while out_ready=0; on out_ready=1 load wait counter=0 -> WAIT.
  - WAIT: line_draw_out=1; counter increments each cycle. Decision is taken in the cycle where counter==WAIT_CYC-1:
    - done=0 -> STEP.
    - done=1 and seg_idx < last -> seg_idx+1, then LOAD.
    - done=1 and seg_idx == last -> FIN.
    - last = 0 for LINE, POLY_SEG-1 for POLY.
- CLEAR path:
  - CSEND: enable=1; hold while out_ready=0; out_ready=1 -> CNEXT.
  - CNEXT: clear_enable=1 -> CWAIT.
  - CWAIT: counts WAIT_CYC cycles like WAIT. In the last cycle: clear_done=1 -> FIN, else -> CSEND.
- FIN: all strobes 0 -> IDLE. render_done=1 exactly in the cycle after FIN (registered), including after abort and illegal op.
- abort=1 in any state other than IDLE/FIN:
  - Combinational strobes (draw_enable, set_new, enable, clear_enable) forced 0 that cycle.
  - Next state FIN; abort has priority over out_ready/done.
  - abort in IDLE/FIN is ignored.
- Input sampling:
  - render_enable while busy is ignored; there is no queueing.
  - op changes after capture are ignored.
  - done/clear_done are ignored outside the decision cycle.
- Exclusivity: set_new implies draw_enable. enable and draw_enable are never high together. Only one of the strobes draw_enable/enable/clear_enable is high per cycle.
- Minimum latency, single-segment LINE, out_ready=1, done=1, WAIT_CYC=2: start sampled at cycle 0 -> LOAD c1, SEND c2, WAIT c3-c4, FIN c5, render_done c6.
- Counter width is 4 bits; seg_idx wraps never (bounded by last).

Test Plan:
- Reset then LINE, WAIT_CYC=2, out_ready=1, done=1 at c4 -> set_new c1, enable c2, FIN c5, render_done single pulse c6, busy c1-c5.
- POLY, POLY_SEG=4, done low for 2 decisions per segment then high -> 4 set_new pulses, seg_idx 0,1,2,3, 12 enable pulses, one render_done.
- CLEAR with clear_done high on the 3rd CWAIT decision -> 3 enable + 3 clear_enable pulses, never line_draw_out, render_done once.
- out_ready low 5 cycles during SEND -> enable held 6 cycles, state frozen, completes normally afterward.
- abort in WAIT of a POLY segment 2 -> no further strobes, FIN next cycle, render_done pulse, seg_idx reset to 0 on next start.
- op=5 -> op_err and render_done pulses, no strobes; synchronous reset asserted in SEND -> all outputs 0 at next edge, IDLE.
